core_alu: RTL and testbench

//  Integer execute unit for the RV32I core. Sits after decode and register read.

---
 rtl/core_alu.sv | 193 +++++++++++++++++++
 tb/tb_core_alu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/core_alu.sv
// RV32I integer execute unit: one-cycle registered result for OP/OP-IMM/LUI/AUIPC/JAL/JALR
// and conditional branch resolution. Control outputs clear on idle cycles; data outputs hold.
module core_alu #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned IMM_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dec_vld,
    input  logic                      dec_req_alu,
    input  logic [31:0]               dec_inst,
    input  logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rf_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
    input  logic [REG_WIDTH-1:0]      rf_rs1,
    input  logic [REG_WIDTH-1:0]      rf_rs2,
    input  logic [PC_WIDTH-1:0]       rf_pc,
    input  logic [IMM_WIDTH-1:0]      dec_imm,
    output logic                      alu_vld,
    output logic                      alu_rd_we,
    output logic [REG_ADDR_WIDTH-1:0] alu_rd_addr,
    output logic [REG_WIDTH-1:0]      alu_rd,
    output logic                      alu_branch,
    output logic                      alu_branch_cond,
    output logic                      alu_branch_taken,
    output logic [PC_WIDTH-1:0]       alu_branch_pc
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OPIMM  = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    logic                      fire;
    opcode_e                   opcode;
    logic [2:0]                funct3;
    logic                      funct7_5;
    logic [REG_WIDTH-1:0]      imm_reg;
    logic [PC_WIDTH-1:0]       imm_pc;
    logic [PC_WIDTH-1:0]       pc_plus4;
    logic [PC_WIDTH-1:0]       pc_rel;
    logic [PC_WIDTH-1:0]       jalr_tgt;
    logic [REG_WIDTH-1:0]      op_b;
    logic [4:0]                shamt;
    logic [REG_WIDTH-1:0]      alu_res;
    logic                      br_res;

    logic                      vld_q, vld_d;
    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]      rd_q, rd_d;
    logic                      br_q, br_d;
    logic                      cond_q, cond_d;
    logic                      taken_q, taken_d;
    logic [PC_WIDTH-1:0]       bpc_q, bpc_d;
    logic                      writes_rd;

    // Register indices and unused instruction fields are informational only.
    logic unused_ok;
    assign unused_ok = ^{rf_rs1_addr, rf_rs2_addr, dec_inst[31], dec_inst[29:15], dec_inst[11:7]};

    assign fire     = dec_vld & dec_req_alu;
    assign opcode   = opcode_e'(dec_inst[6:0]);
    assign funct3   = dec_inst[14:12];
    assign funct7_5 = dec_inst[30];
    assign imm_reg  = REG_WIDTH'(dec_imm);
    assign imm_pc   = PC_WIDTH'(dec_imm);
    assign pc_plus4 = rf_pc + PC_WIDTH'(4);
    assign pc_rel   = rf_pc + imm_pc;
    assign jalr_tgt = PC_WIDTH'(rf_rs1 + imm_reg) & ~PC_WIDTH'(1);
    assign op_b     = (opcode == OPC_OP) ? rf_rs2 : imm_reg;
    assign shamt    = op_b[4:0];

    always_comb begin
        alu_res = '0;
        unique case (funct3)
            3'b000: alu_res = (opcode == OPC_OP && funct7_5) ? rf_rs1 - op_b : rf_rs1 + op_b;
            3'b001: alu_res = rf_rs1 << shamt;
            3'b010: alu_res = REG_WIDTH'($signed(rf_rs1) < $signed(op_b));
            3'b011: alu_res = REG_WIDTH'(rf_rs1 < op_b);
            3'b100: alu_res = rf_rs1 ^ op_b;
            3'b101: alu_res = funct7_5 ? REG_WIDTH'($signed(rf_rs1) >>> shamt) : rf_rs1 >> shamt;
            3'b110: alu_res = rf_rs1 | op_b;
            3'b111: alu_res = rf_rs1 & op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_res = 1'b0;
        case (funct3)
            3'b000: br_res = (rf_rs1 == rf_rs2);
            3'b001: br_res = (rf_rs1 != rf_rs2);
            3'b100: br_res = ($signed(rf_rs1) < $signed(rf_rs2));
            3'b101: br_res = ($signed(rf_rs1) >= $signed(rf_rs2));
            3'b110: br_res = (rf_rs1 < rf_rs2);
            3'b111: br_res = (rf_rs1 >= rf_rs2);
            default: br_res = 1'b0;
        endcase
    end

    always_comb begin
        vld_d     = fire;
        we_d      = 1'b0;
        br_d      = 1'b0;
        cond_d    = 1'b0;
        taken_d   = 1'b0;
        addr_d    = addr_q;
        rd_d      = rd_q;
        bpc_d     = bpc_q;
        writes_rd = 1'b0;
        if (fire) begin
            addr_d = rf_rd_addr;
            rd_d   = '0;
            bpc_d  = pc_plus4;
            case (opcode)
                OPC_OP, OPC_OPIMM: begin
                    rd_d      = alu_res;
                    writes_rd = 1'b1;
                end
                OPC_LUI: begin
                    rd_d      = imm_reg;
                    writes_rd = 1'b1;
                end
                OPC_AUIPC: begin
                    rd_d      = REG_WIDTH'(pc_rel);
                    writes_rd = 1'b1;
                end
                OPC_JAL: begin
                    rd_d      = REG_WIDTH'(pc_plus4);
                    writes_rd = 1'b1;
                    br_d      = 1'b1;
                    taken_d   = 1'b1;
                    bpc_d     = pc_rel;
                end
                OPC_JALR: begin
                    rd_d      = REG_WIDTH'(pc_plus4);
                    writes_rd = 1'b1;
                    br_d      = 1'b1;
                    taken_d   = 1'b1;
                    bpc_d     = jalr_tgt;
                end
                OPC_BRANCH: begin
                    br_d    = 1'b1;
                    cond_d  = 1'b1;
                    taken_d = br_res;
                    bpc_d   = br_res ? pc_rel : pc_plus4;
                end
                default: ;
            endcase
            we_d = writes_rd & (rf_rd_addr != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            rd_q    <= '0;
            br_q    <= 1'b0;
            cond_q  <= 1'b0;
            taken_q <= 1'b0;
            bpc_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            br_q    <= br_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
            bpc_q   <= bpc_d;
        end
    end

    assign alu_vld          = vld_q;
    assign alu_rd_we        = we_q;
    assign alu_rd_addr      = addr_q;
    assign alu_rd           = rd_q;
    assign alu_branch       = br_q;
    assign alu_branch_cond  = cond_q;
    assign alu_branch_taken = taken_q;
    assign alu_branch_pc    = bpc_q;

endmodule

// File: tb/tb_core_alu.sv
// Directed self-checking bench for core_alu with hand-computed expected values.
module tb_core_alu;

    logic        clk;
    logic        rst_n;
    logic        dec_vld;
    logic        dec_req_alu;
    logic [31:0] dec_inst;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rs1;
    logic [31:0] rf_rs2;
    logic [31:0] rf_pc;
    logic [31:0] dec_imm;
    logic        alu_vld;
    logic        alu_rd_we;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd;
    logic        alu_branch;
    logic        alu_branch_cond;
    logic        alu_branch_taken;
    logic [31:0] alu_branch_pc;

    int checks = 0;
    int errors = 0;

    core_alu #(
        .REG_WIDTH      (32),
        .PC_WIDTH       (32),
        .IMM_WIDTH      (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dec_vld          (dec_vld),
        .dec_req_alu      (dec_req_alu),
        .dec_inst         (dec_inst),
        .rf_rs1_addr      (rf_rs1_addr),
        .rf_rs2_addr      (rf_rs2_addr),
        .rf_rd_addr       (rf_rd_addr),
        .rf_rs1           (rf_rs1),
        .rf_rs2           (rf_rs2),
        .rf_pc            (rf_pc),
        .dec_imm          (dec_imm),
        .alu_vld          (alu_vld),
        .alu_rd_we        (alu_rd_we),
        .alu_rd_addr      (alu_rd_addr),
        .alu_rd           (alu_rd),
        .alu_branch       (alu_branch),
        .alu_branch_cond  (alu_branch_cond),
        .alu_branch_taken (alu_branch_taken),
        .alu_branch_pc    (alu_branch_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] op);
        return {f7, 5'd0, 5'd0, f3, 5'd0, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic vld, input logic we, input logic br,
                           input logic cond, input logic taken);
        chk({tag, ".vld"},   {31'd0, alu_vld},          {31'd0, vld});
        chk({tag, ".we"},    {31'd0, alu_rd_we},        {31'd0, we});
        chk({tag, ".br"},    {31'd0, alu_branch},       {31'd0, br});
        chk({tag, ".cond"},  {31'd0, alu_branch_cond},  {31'd0, cond});
        chk({tag, ".taken"}, {31'd0, alu_branch_taken}, {31'd0, taken});
    endtask

    task automatic drive(input logic vld, input logic req, input logic [31:0] inst,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] imm);
        dec_vld     = vld;
        dec_req_alu = req;
        dec_inst    = inst;
        rf_rs1      = rs1;
        rf_rs2      = rs2;
        rf_rd_addr  = rd;
        rf_pc       = pc;
        dec_imm     = imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;

    initial begin
        rst_n       = 1'b0;
        rf_rs1_addr = 5'd1;
        rf_rs2_addr = 5'd2;
        drive(1'b1, 1'b1, $urandom, $urandom, $urandom, 5'($urandom), $urandom, $urandom);
        repeat (3) step();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.rd", alu_rd, 32'h0);
        chk("reset.addr", {27'd0, alu_rd_addr}, 32'h0);
        chk("reset.bpc", alu_branch_pc, 32'h0);

        rst_n = 1'b1;
        drive(1'b0, 1'b0, mk(7'd0, 3'b000, OP), 32'd1, 32'd1, 5'd1, 32'd0, 32'd0);
        step();
        chk("idle.vld", {31'd0, alu_vld}, 32'h0);
        step();
        chk("idle2.vld", {31'd0, alu_vld}, 32'h0);

        drive(1'b1, 1'b1, mk(7'd0, 3'b000, OP), 32'd5, 32'hFFFF_FFFD, 5'd3, 32'd0, 32'd0);
        step();
        chk_ctl("add", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("add.rd", alu_rd, 32'd2);
        chk("add.addr", {27'd0, alu_rd_addr}, 32'd3);

        drive(1'b1, 1'b1, mk(7'b0100000, 3'b000, OP), 32'd3, 32'd5, 5'd4, 32'd0, 32'd0);
        step();
        chk("sub.rd", alu_rd, 32'hFFFF_FFFE);

        drive(1'b1, 1'b1, mk(7'b0100000, 3'b101, OPI), 32'h8000_0000, 32'd0, 5'd5, 32'd0, 32'd4);
        step();
        chk("srai.rd", alu_rd, 32'hF800_0000);

        drive(1'b1, 1'b1, mk(7'd0, 3'b101, OPI), 32'h8000_0000, 32'd0, 5'd5, 32'd0, 32'd4);
        step();
        chk("srli.rd", alu_rd, 32'h0800_0000);

        drive(1'b1, 1'b1, mk(7'd0, 3'b010, OP), 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0, 32'd0);
        step();
        chk("slt.rd", alu_rd, 32'd1);
        drive(1'b1, 1'b1, mk(7'd0, 3'b011, OP), 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0, 32'd0);
        step();
        chk("sltu.rd", alu_rd, 32'd0);

        drive(1'b1, 1'b1, mk(7'd0, 3'b100, BR), 32'hFFFF_FFFF, 32'd1, 5'd7, 32'h100, 32'h20);
        step();
        chk_ctl("blt", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("blt.pc", alu_branch_pc, 32'h120);

        drive(1'b1, 1'b1, mk(7'd0, 3'b110, BR), 32'hFFFF_FFFF, 32'd1, 5'd7, 32'h100, 32'h20);
        step();
        chk_ctl("bltu", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("bltu.pc", alu_branch_pc, 32'h104);

        drive(1'b1, 1'b1, mk(7'd0, 3'b000, 7'b1100111), 32'h203, 32'd0, 5'd1, 32'h40, 32'd2);
        step();
        chk_ctl("jalr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("jalr.rd", alu_rd, 32'h44);
        chk("jalr.pc", alu_branch_pc, 32'h204);

        drive(1'b1, 1'b1, mk(7'd0, 3'b000, OPI), 32'd7, 32'd0, 5'd0, 32'd0, 32'd1);
        step();
        chk_ctl("addi_x0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("addi_x0.rd", alu_rd, 32'd8);

        // Not for this unit: control clears, data holds the ADDI result.
        drive(1'b1, 1'b0, mk(7'd0, 3'b000, 7'b1101111), 32'd9, 32'd9, 5'd9, 32'h80, 32'h10);
        step();
        chk_ctl("noreq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("noreq.rd_hold", alu_rd, 32'd8);

        drive(1'b1, 1'b1, mk(7'd0, 3'b000, 7'b0110111), 32'd0, 32'd0, 5'd5, 32'd0, 32'h1234_5000);
        step();
        chk("b2b_lui.rd", alu_rd, 32'h1234_5000);
        chk("b2b_lui.we", {31'd0, alu_rd_we}, 32'd1);
        drive(1'b1, 1'b1, mk(7'd0, 3'b000, 7'b0010111), 32'd0, 32'd0, 5'd6, 32'h1000, 32'h2000);
        step();
        chk("b2b_auipc.rd", alu_rd, 32'h3000);
        chk("b2b_auipc.addr", {27'd0, alu_rd_addr}, 32'd6);
        drive(1'b1, 1'b1, mk(7'd0, 3'b000, 7'b1101111), 32'd0, 32'd0, 5'd1, 32'h200, 32'hFFFF_FFF8);
        step();
        chk_ctl("b2b_jal", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("b2b_jal.rd", alu_rd, 32'h204);
        chk("b2b_jal.pc", alu_branch_pc, 32'h1F8);

        drive(1'b1, 1'b1, mk(7'd0, 3'b000, 7'b0000000), 32'd3, 32'd4, 5'd2, 32'h10, 32'h5);
        step();
        chk_ctl("unknown", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("unknown.rd", alu_rd, 32'd0);

        drive(1'b1, 1'b1, mk(7'd0, 3'b000, OP), 32'd10, 32'd20, 5'd3, 32'd0, 32'd0);
        step();
        chk("pre_rst.rd", alu_rd, 32'd30);
        drive(1'b1, 1'b1, mk(7'd0, 3'b001, OP), 32'd1, 32'd4, 5'd3, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_ctl("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.rd", alu_rd, 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, mk(7'd0, 3'b001, OP), 32'd1, 32'd4, 5'd3, 32'd0, 32'd0);
        step();
        chk("post_rst.vld", {31'd0, alu_vld}, 32'd0);
        dec_vld = 1'b1;
        step();
        chk_ctl("post_rst_sll", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_sll.rd", alu_rd, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
